board_ram_arbiter: RTL and testbench
====================================

BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

Interface
REQ-001 Parameters SHALL be: CELLS, default 200, number of playfield cells (10 x 20); AW, default 8, address width; DW, default 3, cell colour-index width.
REQ-002 Port iVGA_CLK  in  1  SHALL be the single clock; all logic is posedge.
REQ-003 Port iRST  in  1  SHALL be the reset, synchronous, active-high.
REQ-004 Port vga_req  in  1  SHALL mean the scan-out path requests a cell read this cycle.
REQ-005 Port vga_addr  in  AW  SHALL be the scan-out cell address.
REQ-006 Port vga_data  out  DW  SHALL be the registered scan-out read data.
REQ-007 Port g_req  in  1  SHALL be the game-logic request, level, held until g_ack.
REQ-008 Port g_we  in  1  SHALL select game write (1) or read (0).
REQ-009 Ports g_addr  in  AW  and g_wdata  in  DW  SHALL carry the game address and write data, stable while g_req=1.
REQ-010 Port g_ack  out  1  SHALL be a one-cycle completion pulse.
REQ-011 Port g_rdata  out  DW  SHALL be game read data, valid when g_ack=1.
REQ-012 Port clr_start  in  1  SHALL be a one-cycle board-clear command.
REQ-013 Port busy  out  1  SHALL be high while a clear is running.
REQ-014 Ports ram_addr  out  AW, ram_we  out  1, ram_wdata  out  DW, ram_rdata  in  DW  SHALL drive an external single-port sync RAM with 1-cycle read latency.

Function
REQ-015 Per-cycle RAM priority SHALL be: vga_req > clear write > game access; the port is driven combinationally from the grant.
REQ-016 Scan-out SHALL never stall: vga_data SHALL equal RAM[vga_addr] exactly 2 cycles after vga_req, and SHALL hold its value otherwise.
REQ-017 vga_addr >= CELLS SHALL yield vga_data=0 at the same 2-cycle latency.
REQ-018 FSM states SHALL be IDLE, RDCAP, ACK, CLEAR.
REQ-019 IDLE: pending clear (clr_start now, or latched) SHALL transition to CLEAR with ptr=0; else g_req & ~vga_req SHALL issue the game access in that cycle (T).
REQ-020 Game write issued at T SHALL assert ram_we at T, go to ACK, with g_ack=1 at T+1.
REQ-021 Game read issued at T SHALL go to RDCAP at T+1, capture ram_rdata into g_rdata, then ACK, with g_ack=1 at T+2.
REQ-022 ACK SHALL return to IDLE and SHALL not issue; the earliest next game issue is 2 cycles after a write issue and 3 after a read issue.
REQ-023 g_addr >= CELLS SHALL suppress ram_we (write) or return g_rdata=0 (read), still acked at normal latency.
REQ-024 CLEAR: each cycle with vga_req=0 SHALL write 0 to ptr and increment ptr; cycles with vga_req=1 SHALL not advance ptr.
REQ-025 After writing address CELLS-1 the FSM SHALL return to IDLE; busy SHALL be 1 exactly while state=CLEAR.
REQ-026 clr_start in RDCAP/ACK SHALL be latched and serviced on the next IDLE cycle; clr_start in CLEAR SHALL be ignored.
REQ-027 clr_start coincident with g_req in IDLE: clear SHALL win; the game request SHALL be held off until clear completes.
REQ-028 ram_we SHALL be 0 in every cycle not granted to a clear or game write.

Reset
REQ-029 While iRST=1: state=IDLE, ptr=0, clear latch=0, g_ack=0, g_rdata=0, vga_data=0, busy=0, ram_we=0.
REQ-030 iRST mid-clear or mid-access SHALL abort at once, with no further RAM writes and no g_ack; RAM contents are not restored.

Verification
REQ-031 Preload RAM[5]=3; vga_req=1, vga_addr=5 at cycle 10 -> vga_data=3 at cycle 12.
REQ-032 g_req, g_we=1, g_addr=7, g_wdata=6, vga_req=0 -> ram_we=1 same cycle, g_ack at +1; a later read of 7 -> g_rdata=6 with g_ack at +2.
REQ-033 g_req held with vga_req=1 for 50 cycles -> no issue and no g_ack; vga_req drops -> issue that cycle.
REQ-034 clr_start with vga_req toggling 50% -> busy high until all 200 cells are 0; 200 ram_we pulses, 0 at vga cycles.
REQ-035 clr_start and g_req together -> clear completes first, then exactly one g_ack; g_addr=250 read -> g_rdata=0, acked.
REQ-036 iRST at ptr=100 during clear -> busy=0 next cycle, cells 100..199 unchanged, no ram_we after.

Source files
------------

// File: rtl/board_ram_arbiter.sv
// Single-port playfield RAM arbiter: scan-out reads always win, then the
// board-clear sweep, then game-logic read/write handshakes.
module board_ram_arbiter #(
    parameter int CELLS = 200,
    parameter int AW    = 8,
    parameter int DW    = 3
) (
    input  logic          iVGA_CLK,
    input  logic          iRST,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    output logic          g_ack,
    output logic [DW-1:0] g_rdata,
    input  logic          clr_start,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, RDCAP, ACK, CLEAR} state_t;

    localparam logic [AW:0]   CELLS_X  = (AW+1)'(CELLS);
    localparam logic [AW-1:0] LAST_PTR = AW'(CELLS - 1);

    state_t        state, nextState;
    logic [AW-1:0] ptr, ptrNext;
    logic          clrPend, clrPendNext;
    logic          vld_p1;
    logic          vgaOob_p1;

    function automatic logic inRange(input logic [AW-1:0] a);
        return {1'b0, a} < CELLS_X;
    endfunction

    always_comb begin
        nextState   = state;
        ptrNext     = ptr;
        clrPendNext = clrPend;
        ram_addr    = g_addr;
        ram_we      = 1'b0;
        ram_wdata   = g_wdata;
        if (vga_req)
            ram_addr = vga_addr;
        case (state)
            IDLE: begin
                if (clr_start || clrPend) begin
                    nextState   = CLEAR;
                    ptrNext     = '0;
                    clrPendNext = 1'b0;
                end else if (g_req && !vga_req) begin
                    // Out-of-range writes are acknowledged but never reach the RAM.
                    ram_addr  = g_addr;
                    ram_we    = g_we && inRange(g_addr);
                    nextState = g_we ? ACK : RDCAP;
                end
            end
            RDCAP: begin
                if (clr_start)
                    clrPendNext = 1'b1;
                nextState = ACK;
            end
            ACK: begin
                if (clr_start)
                    clrPendNext = 1'b1;
                nextState = IDLE;
            end
            CLEAR: begin
                if (!vga_req) begin
                    ram_addr  = ptr;
                    ram_we    = 1'b1;
                    ram_wdata = '0;
                    if (ptr == LAST_PTR)
                        nextState = IDLE;
                    else
                        ptrNext = ptr + AW'(1);
                end
            end
            default: nextState = IDLE;
        endcase
        // Reset aborts immediately: no write may land in the reset cycle.
        if (iRST)
            ram_we = 1'b0;
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state     <= IDLE;
            ptr       <= '0;
            clrPend   <= 1'b0;
            vld_p1    <= 1'b0;
            vgaOob_p1 <= 1'b0;
            vga_data  <= '0;
            g_rdata   <= '0;
        end else begin
            state     <= nextState;
            ptr       <= ptrNext;
            clrPend   <= clrPendNext;
            // p1: RAM is reading the scan-out address; p2: registered result
            vld_p1    <= vga_req;
            vgaOob_p1 <= !inRange(vga_addr);
            if (vld_p1)
                vga_data <= vgaOob_p1 ? '0 : ram_rdata;
            if (state == RDCAP)
                g_rdata <= inRange(g_addr) ? ram_rdata : '0;
        end
    end

    assign g_ack = (state == ACK) && !iRST;
    assign busy  = (state == CLEAR) && !iRST;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural 1-cycle sync RAM.
module tb_board_ram_arbiter;

    localparam int CELLS = 200;
    localparam int AW    = 8;
    localparam int DW    = 3;

    logic          clk = 1'b0;
    logic          iRST = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_data;
    logic          g_req = 1'b0;
    logic          g_we = 1'b0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wdata = '0;
    logic          g_ack;
    logic [DW-1:0] g_rdata;
    logic          clr_start = 1'b0;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          preload = 1'b1;
    logic [DW-1:0] mem [256];

    int nTests = 0;
    int nFail  = 0;
    int weCnt = 0;
    int vgaWeCnt = 0;
    int ackCnt = 0;
    int lastVga = 0;

    board_ram_arbiter #(.CELLS(CELLS), .AW(AW), .DW(DW)) dut (
        .iVGA_CLK (clk),
        .iRST     (iRST),
        .vga_req  (vga_req),
        .vga_addr (vga_addr),
        .vga_data (vga_data),
        .g_req    (g_req),
        .g_we     (g_we),
        .g_addr   (g_addr),
        .g_wdata  (g_wdata),
        .g_ack    (g_ack),
        .g_rdata  (g_rdata),
        .clr_start(clr_start),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] patt(input int i);
        return DW'((i % 7) + 1);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= patt(i);
        end else begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_we) weCnt <= weCnt + 1;
        if (ram_we && vga_req) vgaWeCnt <= vgaWeCnt + 1;
        if (g_ack) ackCnt <= ackCnt + 1;
    end

    task automatic checkVal(input string tag, input int got, input int exp);
        nTests++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gameWrite(input int addr, input int data, input int expWe);
        g_req = 1'b1; g_we = 1'b1; g_addr = AW'(addr); g_wdata = DW'(data); vga_req = 1'b0;
        #1;
        checkVal("wr_we", ram_we, expWe);
        if (expWe != 0) checkVal("wr_addr", ram_addr, addr);
        tick();
        checkVal("wr_ack", g_ack, 1);
        g_req = 1'b0;
        tick();
        checkVal("wr_ack_end", g_ack, 0);
    endtask

    task automatic gameRead(input int addr, input int exp);
        g_req = 1'b1; g_we = 1'b0; g_addr = AW'(addr); vga_req = 1'b0;
        #1;
        checkVal("rd_we", ram_we, 0);
        tick();
        checkVal("rd_ack_early", g_ack, 0);
        tick();
        checkVal("rd_ack", g_ack, 1);
        checkVal("rd_data", g_rdata, exp);
        g_req = 1'b0;
        tick();
    endtask

    task automatic vgaRead(input int addr, input int exp);
        vga_req = 1'b1; vga_addr = AW'(addr);
        tick();
        vga_req = 1'b0;
        checkVal("vga_hold", vga_data, lastVga);
        tick();
        checkVal("vga_data", vga_data, exp);
        tick();
        checkVal("vga_keep", vga_data, exp);
        lastVga = exp;
    endtask

    task automatic waitClear(input int toggle, input int pulseAt);
        int i;
        i = 0;
        while (busy && i < 2000) begin
            vga_req = toggle != 0 ? i[0] : 1'b0;
            vga_addr = 8'd250;
            clr_start = (i == pulseAt);
            tick();
            i++;
        end
        clr_start = 1'b0;
        if (toggle != 0) lastVga = 0;
        checkVal("clear_done", busy, 0);
    endtask

    initial begin
        int w0, a0, bad, found;

        // Reset behaviour
        tick(); tick(); tick();
        checkVal("rst_busy", busy, 0);
        checkVal("rst_ack", g_ack, 0);
        checkVal("rst_vga", vga_data, 0);
        checkVal("rst_grd", g_rdata, 0);
        checkVal("rst_we", ram_we, 0);
        preload = 1'b0;
        iRST = 1'b0;
        tick();

        // Scan-out latency and game write/read handshakes
        gameWrite(5, 3, 1);
        vgaRead(5, 3);
        gameWrite(7, 6, 1);
        gameRead(7, 6);
        vgaRead(250, 0);
        vgaRead(101, 4);
        gameWrite(250, 5, 0);
        gameRead(250, 0);
        checkVal("oob_mem", mem[250], 6);

        // Game request starved by continuous scan-out
        w0 = weCnt; a0 = ackCnt;
        g_req = 1'b1; g_we = 1'b1; g_addr = 8'd9; g_wdata = 3'd2;
        vga_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            vga_addr = 8'd250;
            tick();
        end
        checkVal("starve_we", weCnt - w0, 0);
        checkVal("starve_ack", ackCnt - a0, 0);
        vga_req = 1'b0;
        lastVga = 0;
        #1;
        checkVal("starve_issue", ram_we, 1);
        checkVal("starve_addr", ram_addr, 9);
        tick();
        checkVal("starve_ack1", g_ack, 1);
        g_req = 1'b0;
        tick();

        // Clear and game read together, scan-out toggling, stray clr_start mid-clear
        w0 = weCnt; a0 = ackCnt;
        clr_start = 1'b1; g_req = 1'b1; g_we = 1'b0; g_addr = 8'd250;
        tick();
        clr_start = 1'b0;
        checkVal("clr_busy", busy, 1);
        waitClear(1, 60);
        vga_req = 1'b0;
        checkVal("clr_writes", weCnt - w0, CELLS);
        checkVal("clr_vga_we", vgaWeCnt, 0);
        checkVal("clr_noack", ackCnt - a0, 0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (g_ack) begin
                found = 1;
                checkVal("post_clr_rdata", g_rdata, 0);
                g_req = 1'b0;
            end
            tick();
        end
        checkVal("post_clr_acked", found, 1);
        tick(); tick(); tick();
        checkVal("post_clr_ack_cnt", ackCnt - a0, 1);
        checkVal("post_clr_busy", busy, 0);
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] != 0) bad++;
        checkVal("clr_cells", bad, 0);
        checkVal("clr_oob_mem", mem[250], 6);

        // clr_start during ACK is latched and serviced on the next IDLE cycle
        g_req = 1'b1; g_we = 1'b1; g_addr = 8'd3; g_wdata = 3'd5;
        tick();
        g_req = 1'b0;
        clr_start = 1'b1;
        checkVal("latch_ack", g_ack, 1);
        tick();
        clr_start = 1'b0;
        checkVal("latch_idle", busy, 0);
        tick();
        checkVal("latch_busy", busy, 1);
        waitClear(0, -1);
        checkVal("latch_cell3", mem[3], 0);

        // Reset in the middle of a clear
        preload = 1'b1;
        tick();
        preload = 1'b0;
        w0 = weCnt; a0 = ackCnt;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (100) tick();
        iRST = 1'b1;
        #1;
        checkVal("abort_we", ram_we, 0);
        tick();
        checkVal("abort_busy", busy, 0);
        iRST = 1'b0;
        repeat (5) tick();
        checkVal("abort_writes", weCnt - w0, 100);
        checkVal("abort_ack", ackCnt - a0, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) if (mem[i] != 0) bad++;
        for (int i = 100; i < CELLS; i++) if (mem[i] != patt(i)) bad++;
        checkVal("abort_cells", bad, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
